// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU.
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_ACC  = 3'd6,
    OP_CLR  = 3'd7
  } alu_op_t;

  // Ops whose result is also written into the accumulator.
  function automatic logic op_writes_acc(alu_op_t op);
    return (op == OP_ACC) || (op == OP_CLR);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: op, a, b, acc -> result, carry.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] result_c,
  output logic             carry_c
);

  logic [WIDTH:0] sum;

  // Opcode decode; the extra top bit of sum is carry-out for adds and borrow for subtract.
  always_comb begin
    result_c = '0;
    carry_c  = 1'b0;
    sum      = '0;
    case (op)
      OP_AND:  result_c = a & b;
      OP_OR:   result_c = a | b;
      OP_XOR:  result_c = a ^ b;
      OP_NAND: result_c = ~(a & b);
      OP_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        result_c = sum[WIDTH-1:0];
        carry_c  = sum[WIDTH];
      end
      OP_SUB: begin
        sum      = {1'b0, a} - {1'b0, b};
        result_c = sum[WIDTH-1:0];
        carry_c  = sum[WIDTH];
      end
      OP_ACC: begin
        sum      = {1'b0, acc} + {1'b0, a};
        result_c = sum[WIDTH-1:0];
        carry_c  = sum[WIDTH];
      end
      OP_CLR: begin
        result_c = '0;
        carry_c  = 1'b0;
      end
      default: begin
        result_c = '0;
        carry_c  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Single-stage registered ALU with valid/ready handshake and an accumulator.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] result_c;
  logic             carry_c;
  logic             accept_c;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op       (op),
    .a        (a),
    .b        (b),
    .acc      (acc),
    .result_c (result_c),
    .carry_c  (carry_c)
  );

  // One output register: a new request fits if it is empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;

  // Output register, flags and accumulator; held while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      y         <= '0;
      zero      <= 1'b1;
      carry     <= 1'b0;
      acc       <= '0;
    end else begin
      if (accept_c) begin
        out_valid <= 1'b1;
        y         <= result_c;
        zero      <= (result_c == '0);
        carry     <= carry_c;
        if (op_writes_acc(op)) begin
          acc <= result_c;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: vector table, corner sequences, random model check.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int unsigned W   = 16;
  localparam int unsigned MOD = 65536;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  alu_op_t      op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         zero;
  logic         carry;
  logic [W-1:0] acc;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    alu_op_t      op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         zero;
    logic         carry;
  } vec_t;

  vec_t vecs[12];

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .carry     (carry),
    .acc       (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input alu_op_t o, input logic [W-1:0] x,
                       input logic [W-1:0] z, input logic ordy);
    in_valid  = v;
    op        = o;
    a         = x;
    b         = z;
    out_ready = ordy;
  endtask

  // Reference: plain unsigned arithmetic modulo 2^W.
  function automatic void ref_op(input alu_op_t o, input logic [W-1:0] x, input logic [W-1:0] z,
                                 input logic [W-1:0] acc_in, output logic [W-1:0] r, output logic c);
    int unsigned ua   = x;
    int unsigned ub   = z;
    int unsigned uacc = acc_in;
    int unsigned full = 0;
    r = '0;
    c = 1'b0;
    case (o)
      OP_AND:  r = x & z;
      OP_OR:   r = x | z;
      OP_XOR:  r = x ^ z;
      OP_NAND: r = ~(x & z);
      OP_ADD: begin
        full = ua + ub;
        r = W'(full % MOD);
        c = (full >= MOD);
      end
      OP_SUB: begin
        full = ua + MOD - ub;
        r = W'(full % MOD);
        c = (ua < ub);
      end
      OP_ACC: begin
        full = uacc + ua;
        r = W'(full % MOD);
        c = (full >= MOD);
      end
      default: begin
        r = '0;
        c = 1'b0;
      end
    endcase
  endfunction

  logic [W-1:0] acc_exp_y[3];
  logic         acc_exp_c[3];
  logic         mv;
  logic [W-1:0] my;
  logic [W-1:0] macc;
  logic         mc;
  logic         exp_rdy;
  logic         iv;
  logic         ordy;
  alu_op_t      ro;
  logic [W-1:0] ra;
  logic [W-1:0] rb;

  initial begin
    vecs[0]  = '{OP_AND,  16'h00F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0};
    vecs[1]  = '{OP_OR,   16'h00F0, 16'h0FF0, 16'h0FF0, 1'b0, 1'b0};
    vecs[2]  = '{OP_XOR,  16'h00F0, 16'h0FF0, 16'h0F00, 1'b0, 1'b0};
    vecs[3]  = '{OP_NAND, 16'h00F0, 16'h0FF0, 16'hFF0F, 1'b0, 1'b0};
    vecs[4]  = '{OP_ADD,  16'h00F0, 16'h0FF0, 16'h10E0, 1'b0, 1'b0};
    vecs[5]  = '{OP_SUB,  16'h00F0, 16'h0FF0, 16'hF100, 1'b0, 1'b1};
    vecs[6]  = '{OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    vecs[7]  = '{OP_SUB,  16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{OP_CLR,  16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{OP_AND,  16'hAAAA, 16'h5555, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{OP_NAND, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{OP_SUB,  16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1};

    acc_exp_y[0] = 16'h8000; acc_exp_c[0] = 1'b0;
    acc_exp_y[1] = 16'h0000; acc_exp_c[1] = 1'b1;
    acc_exp_y[2] = 16'h8000; acc_exp_c[2] = 1'b0;

    // Reset state
    reset = 1'b1;
    drive(1'b0, OP_AND, '0, '0, 1'b0);
    #12;
    chkb("rst_out_valid", out_valid, 1'b0);
    chkw("rst_y", y, 16'h0000);
    chkb("rst_zero", zero, 1'b1);
    chkb("rst_carry", carry, 1'b0);
    chkw("rst_acc", acc, 16'h0000);
    chkb("rst_in_ready", in_ready, 1'b1);
    step();
    reset = 1'b0;

    // Vector table, one-cycle latency each
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
      step();
      chkb($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
      chkw($sformatf("vec%0d_y", i), y, vecs[i].y);
      chkb($sformatf("vec%0d_zero", i), zero, vecs[i].zero);
      chkb($sformatf("vec%0d_carry", i), carry, vecs[i].carry);
      chkw($sformatf("vec%0d_acc", i), acc, 16'h0000);
    end

    // CLR then three ACC of 0x8000
    drive(1'b1, OP_CLR, 16'h5555, 16'h1111, 1'b1);
    step();
    chkw("clr_y", y, 16'h0000);
    chkb("clr_zero", zero, 1'b1);
    chkb("clr_carry", carry, 1'b0);
    chkw("clr_acc", acc, 16'h0000);
    drive(1'b1, OP_ACC, 16'h8000, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chkw($sformatf("acc%0d_y", i), y, acc_exp_y[i]);
      chkw($sformatf("acc%0d_acc", i), acc, acc_exp_y[i]);
      chkb($sformatf("acc%0d_carry", i), carry, acc_exp_c[i]);
      chkb($sformatf("acc%0d_zero", i), zero, (acc_exp_y[i] == 16'h0000));
    end
    drive(1'b0, OP_AND, '0, '0, 1'b1);
    step();
    chkb("drain_out_valid", out_valid, 1'b0);

    // Backpressure: result held, no acceptance, then consume+accept together
    drive(1'b1, OP_ADD, 16'd1, 16'd2, 1'b0);
    step();
    chkb("bp_out_valid", out_valid, 1'b1);
    chkw("bp_y", y, 16'd3);
    drive(1'b1, OP_XOR, 16'hFFFF, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chkb($sformatf("bp%0d_in_ready", i), in_ready, 1'b0);
      step();
      chkb($sformatf("bp%0d_out_valid", i), out_valid, 1'b1);
      chkw($sformatf("bp%0d_y_held", i), y, 16'd3);
      chkb($sformatf("bp%0d_zero_held", i), zero, 1'b0);
      chkb($sformatf("bp%0d_carry_held", i), carry, 1'b0);
    end
    drive(1'b1, OP_ADD, 16'd10, 16'd20, 1'b1);
    #1;
    chkb("bp_release_in_ready", in_ready, 1'b1);
    step();
    chkb("bp_release_out_valid", out_valid, 1'b1);
    chkw("bp_release_y", y, 16'd30);
    chkw("bp_release_acc", acc, 16'h8000);

    // Back-to-back stream (first 12 cycles) then random handshake traffic
    mv = 1'b1; my = 16'd30; mc = 1'b0; macc = 16'h8000;
    for (int i = 0; i < 400; i++) begin
      iv   = (i < 12) ? 1'b1 : ($urandom_range(0, 3) != 0);
      ordy = (i < 12) ? 1'b1 : ($urandom_range(0, 2) != 0);
      ro   = alu_op_t'(3'($urandom_range(0, 7)));
      ra   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      rb   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      drive(iv, ro, ra, rb, ordy);
      #1;
      exp_rdy = !mv || ordy;
      chkb($sformatf("rnd%0d_in_ready", i), in_ready, exp_rdy);
      step();
      if (iv && exp_rdy) begin
        ref_op(ro, ra, rb, macc, my, mc);
        if (ro == OP_ACC || ro == OP_CLR) macc = my;
        mv = 1'b1;
      end else if (ordy) begin
        mv = 1'b0;
      end
      chkb($sformatf("rnd%0d_out_valid", i), out_valid, mv);
      if (mv) begin
        chkw($sformatf("rnd%0d_y", i), y, my);
        chkb($sformatf("rnd%0d_zero", i), zero, (my == 16'h0000));
        chkb($sformatf("rnd%0d_carry", i), carry, mc);
      end
      chkw($sformatf("rnd%0d_acc", i), acc, macc);
    end

    // Asynchronous reset between edges with a pending result and acc=1234
    drive(1'b1, OP_CLR, '0, '0, 1'b1);
    step();
    drive(1'b1, OP_ACC, 16'h1234, 16'h0000, 1'b1);
    step();
    drive(1'b0, OP_AND, '0, '0, 1'b0);
    chkw("pre_rst_acc", acc, 16'h1234);
    chkb("pre_rst_out_valid", out_valid, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    chkb("async_rst_out_valid", out_valid, 1'b0);
    chkw("async_rst_acc", acc, 16'h0000);
    chkw("async_rst_y", y, 16'h0000);
    chkb("async_rst_zero", zero, 1'b1);
    chkb("async_rst_carry", carry, 1'b0);
    chkb("async_rst_in_ready", in_ready, 1'b1);
    drive(1'b1, OP_ADD, 16'd1, 16'd1, 1'b1);
    step();
    chkb("in_rst_no_accept", out_valid, 1'b0);
    chkw("in_rst_y", y, 16'h0000);
    #2;
    reset = 1'b0;
    drive(1'b0, OP_AND, '0, '0, 1'b1);
    step();
    chkb("post_rst_idle", out_valid, 1'b0);
    drive(1'b1, OP_ADD, 16'd1, 16'd1, 1'b1);
    step();
    chkb("post_rst_out_valid", out_valid, 1'b1);
    chkw("post_rst_y", y, 16'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits (legal range 2..64).
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port in_valid  input  1  operation request present.
REQ-005 Port in_ready  output  1  block accepts request this cycle.
REQ-006 Port op  input  3  opcode, type alu_op_t.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port out_valid  output  1  registered result present.
REQ-010 Port out_ready  input  1  downstream consumes result.
REQ-011 Port y  output  WIDTH  result.
REQ-012 Port zero  output  1  y equals 0.
REQ-013 Port carry  output  1  carry/borrow flag for arithmetic ops.
REQ-014 Port acc  output  WIDTH  current accumulator value.

Function
REQ-015 Opcodes SHALL be: 0 AND (a&b), 1 OR (a|b), 2 XOR (a^b), 3 NAND (~(a&b)), 4 ADD (a+b), 5 SUB (a-b), 6 ACC (acc+a), 7 CLR (0).
REQ-016 Request SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-017 in_ready SHALL equal !out_valid || out_ready (single output register, combinational backpressure pass-through).
REQ-018 Latency SHALL be exactly 1 cycle: result, zero, carry registered on the accepting edge; out_valid set same edge.
REQ-019 out_valid SHALL clear on an edge where out_valid && out_ready and no new request is accepted; simultaneous consume and accept SHALL keep out_valid=1 with new result.
REQ-020 y, zero, carry SHALL hold stable while out_valid && !out_ready.
REQ-021 carry SHALL be carry-out bit WIDTH for ADD and ACC, borrow (a<b unsigned) for SUB, 0 for all other ops.
REQ-022 Arithmetic SHALL be unsigned modulo 2^WIDTH; overflow wraps silently, reported only via carry.
REQ-023 ACC SHALL update acc <= acc+a on the accepting edge and y SHALL be the new acc value.
REQ-024 CLR SHALL set acc and y to 0, zero=1, carry=0.
REQ-025 acc SHALL change only on accepted ACC or CLR; other ops leave it unchanged.
REQ-026 zero SHALL be computed from the registered y, full WIDTH.
REQ-027 All combinational logic SHALL assign every output on every path (default assignment before case); no latch SHALL be inferred.
REQ-028 Opcodes are exhaustive; a default branch SHALL still drive result 0, carry 0.

Reset
REQ-029 Asserting reset SHALL immediately force out_valid=0, y=0, zero=1, carry=0, acc=0, independent of clk.
REQ-030 Reset mid-transfer SHALL discard the pending result; no request is accepted while reset is high.
REQ-031 in_ready SHALL be 1 during and after reset (out_valid=0).

Structure
REQ-032 Package alu_pkg SHALL hold enum alu_op_t (3-bit, eight values above) and the default WIDTH constant.
REQ-033 Sub-module alu_core SHALL be the purely combinational datapath (op, a, b, acc -> result, carry); seq_alu holds the registers and handshake.
REQ-034 Estimated size 150-250 lines total.

Verification
REQ-035 Each op with a=16'h00F0, b=16'h0FF0, out_ready=1 -> next-cycle y = 00F0, 0FF0, 0F00, FF0F, 10E0, F100(carry=1); zero=0.
REQ-036 ADD a=FFFF, b=0001 -> y=0000, zero=1, carry=1.
REQ-037 Three ACC with a=0x8000 after CLR -> acc/y = 8000, 0000 (carry=1, zero=1), 8000.
REQ-038 out_ready=0 for 3 cycles after a result -> in_ready=0, y held; out_ready=1 with in_valid=1 same cycle -> new result next cycle, out_valid never drops.
REQ-039 Reset asserted between clock edges while out_valid=1, acc=1234 -> out_valid=0, acc=0 before next edge.
REQ-040 Back-to-back requests with out_ready=1 for 10 cycles -> one result per cycle, in order, no bubbles.
